// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: byte-wide memory request port, stall/redirect inputs
// and the instruction handed to IF/ID.
interface inst_fetch_if;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_valid;
  logic [7:0]  mem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        if_flag;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    input  stall, branch_flag, branch_target, mem_valid, mem_rdata,
    output mem_req, mem_addr, if_flag, if_pc, if_inst
  );

  modport slave (
    output stall, branch_flag, branch_target, mem_valid, mem_rdata,
    input  mem_req, mem_addr, if_flag, if_pc, if_inst
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, assembles each 32-bit word little-endian from
// four byte reads and hands it to IF/ID with a one-cycle if_flag pulse.
//
// state | meaning
// FETCH | requesting/collecting bytes cnt=0..3
// HOLD  | word complete, waiting for stall[0] to release
// FLUSH | redirect taken while a byte is still outstanding; drop it
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [23:0] byte_buf, byte_buf_nxt;
  logic [31:0] addr, addr_nxt;
  logic [31:0] hold, hold_nxt;
  logic        if_flag, if_flag_nxt;
  logic [31:0] if_pc, if_pc_nxt;
  logic [31:0] if_inst, if_inst_nxt;

  logic [31:0] word;
  logic [31:0] pc_plus4;
  logic        stop;
  logic        unused_stall;

  assign word         = {bus.mem_rdata, byte_buf};
  assign pc_plus4     = pc + 32'd4;
  assign stop         = bus.stall[0];
  assign unused_stall = ^bus.stall[5:1];

  // Outstanding requests are abandoned on reset; the memory side resets too.
  assign bus.mem_req  = !rst && (state != HOLD);
  assign bus.mem_addr = addr;
  assign bus.if_flag  = if_flag;
  assign bus.if_pc    = if_pc;
  assign bus.if_inst  = if_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      cnt      <= 2'd0;
      byte_buf <= 24'd0;
      addr     <= RESET_PC;
      hold     <= 32'd0;
      if_flag  <= 1'b0;
      if_pc    <= 32'd0;
      if_inst  <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      cnt      <= cnt_nxt;
      byte_buf <= byte_buf_nxt;
      addr     <= addr_nxt;
      hold     <= hold_nxt;
      if_flag  <= if_flag_nxt;
      if_pc    <= if_pc_nxt;
      if_inst  <= if_inst_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    cnt_nxt      = cnt;
    byte_buf_nxt = byte_buf;
    addr_nxt     = addr;
    hold_nxt     = hold;
    if_flag_nxt  = 1'b0;
    if_pc_nxt    = if_pc;
    if_inst_nxt  = if_inst;

    case (state)
      FETCH: begin
        if (bus.branch_flag) begin
          // Redirect beats a same-cycle completion; the word is discarded.
          pc_nxt       = bus.branch_target;
          cnt_nxt      = 2'd0;
          byte_buf_nxt = 24'd0;
          if (bus.mem_valid) begin
            addr_nxt = bus.branch_target;
          end else begin
            state_nxt = FLUSH;
          end
        end else if (bus.mem_valid) begin
          if (cnt != 2'd3) begin
            case (cnt)
              2'd0:    byte_buf_nxt[7:0]   = bus.mem_rdata;
              2'd1:    byte_buf_nxt[15:8]  = bus.mem_rdata;
              default: byte_buf_nxt[23:16] = bus.mem_rdata;
            endcase
            cnt_nxt  = cnt + 2'd1;
            addr_nxt = pc + {30'd0, cnt} + 32'd1;
          end else if (!stop) begin
            if_flag_nxt = 1'b1;
            if_inst_nxt = word;
            if_pc_nxt   = pc_plus4;
            pc_nxt      = pc_plus4;
            addr_nxt    = pc_plus4;
            cnt_nxt     = 2'd0;
          end else begin
            hold_nxt  = word;
            cnt_nxt   = 2'd0;
            state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.branch_flag) begin
          pc_nxt       = bus.branch_target;
          addr_nxt     = bus.branch_target;
          cnt_nxt      = 2'd0;
          byte_buf_nxt = 24'd0;
          state_nxt    = FETCH;
        end else if (!stop) begin
          if_flag_nxt = 1'b1;
          if_inst_nxt = hold;
          if_pc_nxt   = pc_plus4;
          pc_nxt      = pc_plus4;
          addr_nxt    = pc_plus4;
          cnt_nxt     = 2'd0;
          state_nxt   = FETCH;
        end
      end

      FLUSH: begin
        // addr stays on the in-flight byte until it returns, then is dropped.
        if (bus.branch_flag) begin
          pc_nxt = bus.branch_target;
        end
        if (bus.mem_valid) begin
          addr_nxt  = bus.branch_flag ? bus.branch_target : pc;
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a byte memory model answers requests and each
// scenario compares outputs against hand-computed addresses and words.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bytes 0..3 hold addi a0,x0,1; everything else is addr[7:0]^8'h5A.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'd0:   b = 8'h13;
      32'd1:   b = 8'h05;
      32'd2:   b = 8'h10;
      32'd3:   b = 8'h00;
      default: b = a[7:0] ^ 8'h5A;
    endcase
    return b;
  endfunction

  // One cycle: present inputs (valid only answers a live request), then clock.
  task automatic step(input logic v, input logic s, input logic br, input logic [31:0] tgt);
    bus.mem_valid     = v & bus.mem_req;
    bus.mem_rdata     = mem_byte(bus.mem_addr);
    bus.stall         = {5'd0, s};
    bus.branch_flag   = br;
    bus.branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_valid     = 1'b0;
    bus.mem_rdata     = 8'd0;
    bus.stall         = 6'd0;
    bus.branch_flag   = 1'b0;
    bus.branch_target = 32'd0;

    // Reset values and a plain fetch of the first word.
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    chk("rst_flag", bus.if_flag, 0);
    chk("rst_pc", bus.if_pc, 0);
    chk("rst_inst", bus.if_inst, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    rst = 1'b0;
    #1;
    chk("req_after_rst", bus.mem_req, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", bus.mem_addr, i);
      chk("t1_noflag", bus.if_flag, 0);
      step(1, 0, 0, 32'd0);
    end
    chk("t1_flag", bus.if_flag, 1);
    chk("t1_inst", bus.if_inst, 32'h0010_0513);
    chk("t1_pc", bus.if_pc, 32'd4);
    chk("t1_next_addr", bus.mem_addr, 32'd4);
    step(1, 0, 0, 32'd0);
    chk("t1_pulse", bus.if_flag, 0);
    chk("t1_inst_kept", bus.if_inst, 32'h0010_0513);

    // Stall asserted in cycles 2..10 of the first fetch.
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      if (c >= 4 && c <= 10) chk("t2_hold_req", bus.mem_req, 0);
      chk("t2_noflag", bus.if_flag, 0);
      step(1, (c >= 2 && c <= 10), 0, 32'd0);
    end
    chk("t2_flag", bus.if_flag, 1);
    chk("t2_pc", bus.if_pc, 32'd4);
    chk("t2_inst", bus.if_inst, 32'h0010_0513);
    chk("t2_req", bus.mem_req, 1);
    chk("t2_addr", bus.mem_addr, 32'd4);

    // Redirect while byte 2 is in flight; the byte returns 3 cycles late.
    do_reset();
    step(1, 0, 0, 32'd0);
    step(1, 0, 0, 32'd0);
    chk("t3_addr2", bus.mem_addr, 32'd2);
    step(0, 0, 1, 32'h100);
    for (int k = 0; k < 2; k++) begin
      chk("t3_held", bus.mem_addr, 32'd2);
      chk("t3_req", bus.mem_req, 1);
      step(0, 0, 0, 32'd0);
    end
    chk("t3_held_last", bus.mem_addr, 32'd2);
    step(1, 0, 0, 32'd0);
    chk("t3_tgt", bus.mem_addr, 32'h100);
    for (int i = 0; i < 4; i++) begin
      chk("t3_noflag", bus.if_flag, 0);
      step(1, 0, 0, 32'd0);
    end
    chk("t3_flag", bus.if_flag, 1);
    chk("t3_pc", bus.if_pc, 32'h104);
    chk("t3_inst", bus.if_inst, 32'h5958_5B5A);
    chk("t3_next_addr", bus.mem_addr, 32'h104);

    // Redirect coincident with the fourth byte.
    do_reset();
    step(1, 0, 0, 32'd0);
    step(1, 0, 0, 32'd0);
    step(1, 0, 0, 32'd0);
    step(1, 0, 1, 32'h200);
    chk("t4_noflag", bus.if_flag, 0);
    chk("t4_pc_kept", bus.if_pc, 32'd0);
    chk("t4_addr", bus.mem_addr, 32'h200);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'd0);
    chk("t4_flag", bus.if_flag, 1);
    chk("t4_pc", bus.if_pc, 32'h204);
    chk("t4_inst", bus.if_inst, 32'h5958_5B5A);

    // Fetch across the top of the address space.
    do_reset();
    step(1, 0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      chk("t5_addr", bus.mem_addr, 32'hFFFF_FFFC + i);
      step(1, 0, 0, 32'd0);
    end
    chk("t5_flag", bus.if_flag, 1);
    chk("t5_pc", bus.if_pc, 32'd0);
    chk("t5_inst", bus.if_inst, 32'hA5A4_A7A6);
    chk("t5_next_addr", bus.mem_addr, 32'd0);

    // Reset in the middle of a fetch (cnt=2).
    step(1, 0, 0, 32'd0);
    step(1, 0, 0, 32'd0);
    chk("t6_addr2", bus.mem_addr, 32'd2);
    rst = 1'b1;
    #1;
    chk("t6_req_rst", bus.mem_req, 0);
    step(0, 0, 0, 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_flag", bus.if_flag, 0);
    chk("t6_pc", bus.if_pc, 32'd0);
    chk("t6_inst", bus.if_inst, 32'd0);
    chk("t6_addr", bus.mem_addr, 32'd0);
    chk("t6_req", bus.mem_req, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'd0);
    chk("t6_refetch_flag", bus.if_flag, 1);
    chk("t6_refetch_inst", bus.if_inst, 32'h0010_0513);
    chk("t6_refetch_pc", bus.if_pc, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
